// File: rtl/ic_fill_ctrl.sv
// I-cache line fill engine: queues fill requests and serves each one as 4 word reads, returning a 128-bit line.
// Fill result 5 cycles after the request pops (zero backing latency); no backpressure on mem_ic_valid.
module ic_fill_ctrl #(
    parameter int DEPTH = 4,
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [22:0]           ic_mem_addr,
    input  logic [1:0]            ic_mem_xid,
    input  logic                  ic_mem_re,
    output logic                  mem_ic_ready,
    output logic                  mem_ic_valid,
    output logic [1:0]            mem_ic_xid,
    output logic [127:0]          mem_ic_data,
    output logic                  bk_req,
    output logic [24:0]           bk_addr,
    input  logic                  bk_gnt,
    input  logic                  bk_rvalid,
    input  logic [31:0]           bk_rdata
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [2:0]  LAST = 3'(BEATS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    logic [22:0]            r_fifo_addr [DEPTH];
    logic [1:0]             r_fifo_xid  [DEPTH];
    logic [AW:0]            r_wptr, r_rptr;
    logic                   r_ready;
    state_t                 r_state, w_state_nxt;
    logic [22:0]            r_line_addr;
    logic [1:0]             r_xid;
    logic [2:0]             r_iss_cnt, r_rcv_cnt, w_iss_nxt, w_rcv_nxt;
    logic [BEATS-1:0][31:0] r_line, w_line_nxt;
    logic                   r_bk_req;
    logic [24:0]            r_bk_addr;
    logic                   r_valid;
    logic [1:0]             r_out_xid;
    logic [BEATS-1:0][31:0] r_out_data;
    logic [AW:0]            w_count, w_count_nxt;
    logic                   w_push, w_pop, w_gnt, w_rcv;

    assign mem_ic_ready = r_ready;
    assign mem_ic_valid = r_valid;
    assign mem_ic_xid   = r_out_xid;
    assign mem_ic_data  = r_out_data;
    assign bk_req       = r_bk_req;
    assign bk_addr      = r_bk_addr;

    assign w_count     = r_wptr - r_rptr;
    assign w_push      = ic_mem_re && r_ready;
    assign w_pop       = (r_state == S_IDLE) && (w_count != '0);
    assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr[AW-1:0]] <= ic_mem_addr;
            r_fifo_xid[r_wptr[AW-1:0]]  <= ic_mem_xid;
        end
    end

    // Ready is registered from the post-edge occupancy, so a pop on a full FIFO frees a slot one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ready <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_ready <= (w_count_nxt != FULL);
        end
    end

    // Beats are accepted only against outstanding grants, which makes stale or spurious returns harmless.
    always_comb begin
        w_gnt      = (r_state == S_ISSUE) && r_bk_req && bk_gnt;
        w_rcv      = bk_rvalid && ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                     (r_iss_cnt != r_rcv_cnt);
        w_iss_nxt  = r_iss_cnt + 3'(w_gnt);
        w_rcv_nxt  = r_rcv_cnt + 3'(w_rcv);
        w_line_nxt = r_line;
        if (w_rcv) w_line_nxt[r_rcv_cnt[1:0]] = bk_rdata;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_count != '0) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_iss_nxt == LAST) w_state_nxt = (w_rcv_nxt == LAST) ? S_RESP : S_WAIT;
            S_WAIT:  if (w_rcv_nxt == LAST) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_line_addr <= '0;
            r_xid       <= '0;
            r_iss_cnt   <= '0;
            r_rcv_cnt   <= '0;
            r_line      <= '0;
            r_bk_req    <= 1'b0;
            r_bk_addr   <= '0;
            r_valid     <= 1'b0;
            r_out_xid   <= '0;
            r_out_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            if (w_pop) begin
                r_line_addr <= r_fifo_addr[r_rptr[AW-1:0]];
                r_xid       <= r_fifo_xid[r_rptr[AW-1:0]];
                r_iss_cnt   <= '0;
                r_rcv_cnt   <= '0;
                r_bk_req    <= 1'b1;
                r_bk_addr   <= {r_fifo_addr[r_rptr[AW-1:0]], 2'b00};
            end else begin
                r_iss_cnt <= w_iss_nxt;
                r_rcv_cnt <= w_rcv_nxt;
                if (w_gnt) begin
                    if (w_iss_nxt == LAST) r_bk_req <= 1'b0;
                    else                   r_bk_addr <= {r_line_addr, w_iss_nxt[1:0]};
                end
            end
            r_valid <= (w_state_nxt == S_RESP);
            if (w_state_nxt == S_RESP) begin
                r_out_data <= w_line_nxt;
                r_out_xid  <= r_xid;
            end
        end
    end
endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Directed bench for ic_fill_ctrl with a backing-memory model and a response scoreboard.
module tb_ic_fill_ctrl;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [22:0]  ic_mem_addr;
    logic [1:0]   ic_mem_xid;
    logic         ic_mem_re;
    logic         mem_ic_ready, mem_ic_valid;
    logic [1:0]   mem_ic_xid;
    logic [127:0] mem_ic_data;
    logic         bk_req, bk_gnt, bk_rvalid;
    logic [24:0]  bk_addr;
    logic [31:0]  bk_rdata;

    always #5 clk = ~clk;

    ic_fill_ctrl #(.DEPTH(4), .BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_mem_addr(ic_mem_addr), .ic_mem_xid(ic_mem_xid), .ic_mem_re(ic_mem_re),
        .mem_ic_ready(mem_ic_ready), .mem_ic_valid(mem_ic_valid),
        .mem_ic_xid(mem_ic_xid), .mem_ic_data(mem_ic_data),
        .bk_req(bk_req), .bk_addr(bk_addr), .bk_gnt(bk_gnt),
        .bk_rvalid(bk_rvalid), .bk_rdata(bk_rdata)
    );

    typedef struct {
        logic [22:0]  addr;
        logic [1:0]   xid;
        int           gnt_mode;
        int           lat;
        logic [127:0] exp_data;
    } vec_t;
    typedef struct { int due; logic [31:0] data; } beat_t;
    typedef struct { logic [1:0] xid; logic [127:0] data; } resp_t;

    beat_t       rq[$];
    logic [22:0] issue_q[$];
    resp_t       resp_q[$];
    int          cyc, gi, n_gnt, gnt_mode, lat;
    int          n_chk, n_pass;
    logic        model_rv, force_rv;
    logic [31:0] force_data;

    // Backing memory content: word k of line L is 0x11111111*(k+1) plus (L[7:0]-0x40) in the top byte.
    function automatic logic [31:0] mem_word(input logic [24:0] wa);
        logic [31:0] base;
        logic [7:0]  off;
        base = 32'h11111111 * ({30'b0, wa[1:0]} + 32'd1);
        off  = wa[9:2] - 8'h40;
        return base + {off, 24'h0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        logic        g, ph_req, ph_gnt;
        logic [24:0] a;
        beat_t       b;
        resp_t       r;
        g      = bk_req && bk_gnt;
        a      = bk_addr;
        ph_req = bk_req;
        ph_gnt = bk_gnt;
        if (model_rv) rq.delete(0);
        @(posedge clk);
        #1;
        cyc++;
        if (g) begin
            b.due  = cyc - 1 + lat;
            b.data = mem_word(a);
            rq.push_back(b);
            n_gnt++;
            if (issue_q.size() > 0) begin
                chk("grant_addr", a, {issue_q[0], gi[1:0]});
                gi++;
                if (gi == 4) begin
                    gi = 0;
                    issue_q.delete(0);
                end
            end else begin
                chk("unexpected_grant", 1, 0);
            end
        end
        if (ph_req && !ph_gnt && bk_req && rst_n) chk("bk_addr_hold", bk_addr, a);
        if (mem_ic_valid) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                r = resp_q[0];
                chk("resp_xid", mem_ic_xid, r.xid);
                chk("resp_data", mem_ic_data, r.data);
                resp_q.delete(0);
            end
        end
        bk_gnt    = (gnt_mode == 1) || ((gnt_mode == 2) && cyc[0]);
        model_rv  = !force_rv && (rq.size() > 0) && (rq[0].due <= cyc);
        bk_rvalid = force_rv || model_rv;
        bk_rdata  = force_rv ? force_data : (model_rv ? rq[0].data : 32'h0);
    endtask

    task automatic enqueue(input logic [22:0] addr, input logic [1:0] xid, input logic acc,
                           input logic [127:0] exp_data);
        resp_t r;
        chk("ready_before_req", mem_ic_ready, acc);
        ic_mem_re   = 1'b1;
        ic_mem_addr = addr;
        ic_mem_xid  = xid;
        if (acc) begin
            issue_q.push_back(addr);
            r.xid  = xid;
            r.data = exp_data;
            resp_q.push_back(r);
        end
        tick();
        ic_mem_re = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (resp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_timeout", resp_q.size(), 0);
        repeat (4) tick();
    endtask

    task automatic wait_pulse(input int bound);
        int n;
        n = 0;
        while (!mem_ic_valid && n < bound) begin
            tick();
            n++;
        end
        chk("pulse_timeout", mem_ic_valid, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, mem_ic_ready, 0);
        chk({tag, "_valid"}, mem_ic_valid, 0);
        chk({tag, "_xid"}, mem_ic_xid, 0);
        chk({tag, "_data"}, mem_ic_data, 0);
        chk({tag, "_bk_req"}, bk_req, 0);
        chk({tag, "_bk_addr"}, bk_addr, 0);
    endtask

    initial begin
        vec_t        tv[4];
        logic [1:0]  kk;
        int          base, n;

        tv[0] = '{23'h000040, 2'd2, 1, 1, 128'h44444444_33333333_22222222_11111111};
        tv[1] = '{23'h000041, 2'd1, 2, 3, 128'h45444444_34333333_23222222_12111111};
        tv[2] = '{23'h7FFFC0, 2'd3, 1, 2, 128'hC4444444_B3333333_A2222222_91111111};
        tv[3] = '{23'h00007F, 2'd0, 2, 1, 128'h83444444_72333333_61222222_50111111};

        rst_n = 1'b0; ic_mem_re = 1'b0; ic_mem_addr = '0; ic_mem_xid = '0;
        bk_gnt = 1'b0; bk_rvalid = 1'b0; bk_rdata = '0;
        cyc = 0; gi = 0; n_gnt = 0; gnt_mode = 1; lat = 1;
        n_chk = 0; n_pass = 0; model_rv = 1'b0; force_rv = 1'b0; force_data = '0;

        #2;
        chk_zero("reset");
        @(posedge clk);
        #1;
        chk("ready_in_reset", mem_ic_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", mem_ic_ready, 1);
        chk("bk_req_idle", bk_req, 0);

        // Single fills under different grant/latency patterns.
        for (int i = 0; i < 4; i++) begin
            gnt_mode = tv[i].gnt_mode;
            lat      = tv[i].lat;
            tick();
            enqueue(tv[i].addr, tv[i].xid, 1'b1, tv[i].exp_data);
            if (tv[i].gnt_mode == 1 && tv[i].lat == 1) begin
                chk("t0_bk_req", bk_req, 0);
                for (int k = 1; k <= 6; k++) begin
                    tick();
                    if (k <= 4) begin
                        kk = 2'(k - 1);
                        chk("timing_bk_req", bk_req, 1);
                        chk("timing_bk_addr", bk_addr, {tv[i].addr, kk});
                    end else begin
                        chk("timing_bk_req_off", bk_req, 0);
                    end
                    chk("timing_valid", mem_ic_valid, (k == 6));
                end
            end
            drain(100);
            chk("data_hold", mem_ic_data, tv[i].exp_data);
            chk("xid_hold", mem_ic_xid, tv[i].xid);
        end

        // Spurious returns while idle.
        gnt_mode = 1; lat = 1;
        force_data = 32'hDEADBEEF;
        force_rv = 1'b1;
        repeat (3) tick();
        force_rv = 1'b0;
        tick();
        enqueue(23'h000043, 2'd1, 1'b1, 128'h47444444_36333333_25222222_14111111);
        drain(100);

        // Fill the FIFO behind a stalled fill, reject one extra, then check ready recovery timing.
        gnt_mode = 0;
        tick();
        enqueue(23'h000050, 2'd3, 1'b1, 128'h54444444_43333333_32222222_21111111);
        enqueue(23'h000042, 2'd0, 1'b1, 128'h46444444_35333333_24222222_13111111);
        enqueue(23'h000043, 2'd1, 1'b1, 128'h47444444_36333333_25222222_14111111);
        enqueue(23'h000044, 2'd2, 1'b1, 128'h48444444_37333333_26222222_15111111);
        enqueue(23'h000045, 2'd3, 1'b1, 128'h49444444_38333333_27222222_16111111);
        chk("ready_full", mem_ic_ready, 0);
        enqueue(23'h000046, 2'd0, 1'b0, '0);
        repeat (3) tick();
        chk("ready_full_hold", mem_ic_ready, 0);
        chk("stall_bk_req", bk_req, 1);
        chk("stall_bk_addr", bk_addr, 25'h000140);
        gnt_mode = 1;
        wait_pulse(50);
        chk("ready_at_resp", mem_ic_ready, 0);
        tick();
        chk("ready_idle_full", mem_ic_ready, 0);
        tick();
        chk("ready_after_pop", mem_ic_ready, 1);
        chk("bk_req_after_pop", bk_req, 1);
        drain(200);

        // Reset in the middle of a fill with beats still in flight.
        gnt_mode = 1; lat = 4;
        tick();
        base = n_gnt;
        enqueue(23'h000041, 2'd2, 1'b1, '0);
        n = 0;
        while (n_gnt < base + 2 && n < 50) begin
            tick();
            n++;
        end
        chk("two_grants", n_gnt - base, 2);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        issue_q.delete();
        resp_q.delete();
        gi = 0;
        tick();
        chk_zero("midreset_hold");
        rst_n = 1'b1;
        n = 0;
        while (rq.size() > 0 && n < 20) begin
            tick();
            chk("stale_no_req", bk_req, 0);
            n++;
        end
        chk("stale_beats_done", rq.size(), 0);
        lat = 1;
        enqueue(23'h000040, 2'd1, 1'b1, 128'h44444444_33333333_22222222_11111111);
        drain(100);
        chk("post_reset_xid", mem_ic_xid, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ic_fill_ctrl.md
Name: ic_fill_ctrl

Overview:
- Memory-side fill engine for the instruction cache; sits directly upstream of the cache's miss interface.
- Accepts line-fill requests (addr[26:4], 2-bit xid) into a small FIFO.
- Serves each request as 4 single-word reads on a 32-bit backing-memory port, assembles the 128-bit line, and returns it with the original xid.
- One line in flight at a time; requests complete in acceptance order.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2).
- BEATS, 4, words per line (fixed: 128/32; not to be overridden).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ic_mem_addr  in  23  [26:4] line address of fill request.
- ic_mem_xid  in  2  request transaction id.
- ic_mem_re  in  1  fill request strobe.
- mem_ic_ready  out  1  FIFO can accept a request this cycle.
- mem_ic_valid  out  1  one-cycle pulse: fill data valid.
- mem_ic_xid  out  2  xid of returned line.
- mem_ic_data  out  128  returned line; word k in [32k+31:32k].
- bk_req  out  1  backing read request.
- bk_addr  out  25  [26:2] word address.
- bk_gnt  in  1  request accepted this cycle (bk_req && bk_gnt).
- bk_rvalid  in  1  read data beat valid; beats return in request order.
- bk_rdata  in  32  read data.

Behaviour:
- Reset, async: FIFO empty; FSM IDLE; all counters 0; mem_ic_valid=0, mem_ic_xid=0, mem_ic_data=0, bk_req=0, bk_addr=0. mem_ic_ready=0 while rst_n low, 1 from the first edge after release.
- mem_ic_ready = (fifo count < DEPTH), registered. Enqueue when ic_mem_re && mem_ic_ready.
- ic_mem_re while ready=0: request dropped; the cache must not do this.
- No duplicate-xid check.
- FIFO full: ready low; no enqueue, even if a dequeue happens the same cycle.
- Empty FIFO with simultaneous enqueue/dequeue cannot happen: dequeue needs count≥1 at the edge.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into line_addr/xid regs; clear iss_cnt, rcv_cnt; go ISSUE.
  - ISSUE: bk_req=1; bk_addr={line_addr, iss_cnt[1:0]}. On bk_gnt, iss_cnt++. When the grant of beat 3 occurs, bk_req deasserts the next cycle; go WAIT.
  - WAIT: receive remaining beats, then go RESP.
  - RESP: mem_ic_valid=1 for exactly one cycle with assembled data and xid; next state IDLE.
- Beat reception is active in ISSUE and WAIT.
  - On bk_rvalid with outstanding (iss_cnt−rcv_cnt) > 0: write bk_rdata to word rcv_cnt; rcv_cnt++.
  - bk_rvalid with outstanding==0 (including in IDLE/RESP, or stale after reset): ignored.
- A beat may return in the same cycle as a later grant; both counters update.
- WAIT→RESP on the edge where rcv_cnt reaches 4. ISSUE may also go directly to RESP if all 4 beats have arrived by the final grant (not possible with in-order 1+ cycle latency, but legal).
- Registered-output timing:
  - bk_req/bk_addr come from flops.
  - Enqueue at edge t → IDLE pops at edge t+1 → bk_req high in cycle t+1.
  - With bk_gnt=1 always and rvalid 1 cycle after grant: grants in t+1..t+4, rvalid in t+2..t+5, mem_ic_valid high in cycle t+6.
- mem_ic_data/xid hold their last values after the valid pulse.
- mem_ic_valid has no backpressure; the consumer must always accept.
- Next request: leaving RESP→IDLE costs one cycle, so line issue rate is at most 1 per 7 cycles at zero latency.
- Reset mid-operation: everything is cleared immediately. Returning backing beats are ignored because outstanding==0. FIFO contents are lost.
- Widths: iss_cnt, rcv_cnt are 3 bits (0..4); FIFO pointers are log2(DEPTH)+1 bits with wrap.

Test Plan:
1. Single fill at addr 23'h00_0040, xid 2; bk_gnt=1, 1-cycle latency, rdata=0x11111111·(k+1).
   → bk_addr 0x100..0x103; mem_ic_valid in cycle t+6 with data 0x44444444_33333333_22222222_11111111, xid 2.
2. Fill 4 requests back-to-back (xids 0,1,2,3) while bk_gnt held low.
   → ready drops after the 4th accept; a 5th re while ready=0 is not enqueued.
   → after releasing gnt, 4 valid pulses arrive in xid order 0,1,2,3.
3. Stall patterns: bk_gnt toggling 1,0,1,0 and rvalid latency 3 cycles.
   → bk_addr holds its value while gnt=0; the line is assembled correctly; exactly one valid pulse.
4. Spurious bk_rvalid in IDLE (rdata 0xDEADBEEF) before a fill.
   → ignored; the following fill's data contains no 0xDEADBEEF.
5. Assert rst_n low after 2 granted beats, release, then 2 stale rvalid beats arrive followed by a new fill with xid 1.
   → stale beats ignored; all outputs are 0 during reset; the new fill returns correct data with xid 1.
6. Full FIFO with the head being served: dequeue at edge n.
   → ready rises in the cycle after n, not the same cycle; no request is lost or duplicated.
